// File: rtl/fb_access_arbiter.sv
// Framebuffer port arbiter: fixed-latency scanout reads, FIFO-buffered renderer
// writes drained into idle slots, and a full-screen clear engine.
module fb_access_arbiter #(
  parameter int FB_DEPTH   = 19200,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  // state | meaning
  // IDLE  | renderer writes accepted, FIFO drains into free slots
  // DRAIN | clear requested, waiting for FIFO to empty
  // CLEAR | sweeping fill color over the whole framebuffer
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_full, fifo_empty, push, pop;

  logic [ADDR_W-1:0] sweep_addr;
  logic [DATA_W-1:0] fill_color;
  logic              sweep_go, sweep_rst, load_color, done_nxt, rd_issued;

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign wr_ready   = !fifo_full && (state == IDLE) && !reset;
  assign push       = wr_valid && wr_ready;
  assign clear_busy = (state != IDLE);
  assign rd_data    = mem_rdata;

  always_comb begin
    state_nxt  = state;
    load_color = 1'b0;
    sweep_rst  = 1'b0;
    done_nxt   = 1'b0;
    pop        = !rd_req && (state != CLEAR) && !fifo_empty;
    sweep_go   = !rd_req && (state == CLEAR);
    case (state)
      IDLE: begin
        if (clear_start) begin
          load_color = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          sweep_rst = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (sweep_go && (sweep_addr == LAST_ADDR)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      sweep_addr <= '0;
      fill_color <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      rd_issued  <= 1'b0;
      rd_valid   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_done <= done_nxt;
      rd_issued  <= rd_req;
      rd_valid   <= rd_issued;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (load_color) fill_color <= clear_color;
      if (sweep_rst)     sweep_addr <= '0;
      else if (sweep_go) sweep_addr <= sweep_addr + 1'b1;
      // One RAM slot per cycle: scanout read beats FIFO drain beats sweep.
      mem_we <= 1'b0;
      if (rd_req) begin
        mem_addr <= rd_addr;
      end else if (pop) begin
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
        mem_we    <= 1'b1;
      end else if (sweep_go) begin
        mem_addr  <= sweep_addr;
        mem_wdata <= fill_color;
        mem_we    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a small RAM model and write/read logs.
module tb_fb_access_arbiter;
  localparam int FB_DEPTH   = 16;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 3;
  localparam int FIFO_DEPTH = 4;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              clear_start = 1'b0;
  logic [DATA_W-1:0] clear_color = '0;
  logic              clear_busy, clear_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  fb_access_arbiter #(.FB_DEPTH(FB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // RAM model: unwritten words read as addr&7, one-cycle read latency.
  logic [2:0]   ram [256];
  logic [255:0] written = '0;
  always @(posedge CLOCK_50) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr[7:0]]     <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    mem_rdata <= written[mem_addr[7:0]] ? ram[mem_addr[7:0]] : mem_addr[2:0];
  end

  function automatic int ram_rd(input int a);
    return written[a] ? int'(ram[a]) : (a & 7);
  endfunction

  int wlog_a[$], wlog_d[$], wlog_c[$], rlog_d[$], rlog_c[$], riss[$];
  int done_cnt, done_cyc, busy_cnt, busy_first, ready_in_busy, done_busy_bad;

  always @(negedge CLOCK_50) begin
    if (mem_we === 1'b1) begin
      wlog_a.push_back(int'(mem_addr));
      wlog_d.push_back(int'(mem_wdata));
      wlog_c.push_back(cyc);
    end
    if (rd_valid === 1'b1) begin
      rlog_d.push_back(int'(rd_data));
      rlog_c.push_back(cyc);
    end
    if (clear_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (clear_busy !== 1'b0) done_busy_bad++;
    end
    if (clear_busy === 1'b1) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_cnt++;
      if (wr_ready !== 1'b0) ready_in_busy++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
    rlog_d.delete(); rlog_c.delete(); riss.delete();
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; busy_first = 0;
    ready_in_busy = 0; done_busy_bad = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"},     32'(mem_we), 0);
    chk({tag, "_mem_addr"},   32'(mem_addr), 0);
    chk({tag, "_mem_wdata"},  32'(mem_wdata), 0);
    chk({tag, "_rd_valid"},   32'(rd_valid), 0);
    chk({tag, "_clear_busy"}, 32'(clear_busy), 0);
    chk({tag, "_clear_done"}, 32'(clear_done), 0);
    chk({tag, "_wr_ready"},   32'(wr_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r, k, t, wsz;
    logic acc, found;
    clear_logs();

    // Reset
    repeat (3) @(negedge CLOCK_50);
    chk("rst_wr_ready_in_reset", 32'(wr_ready), 0);
    tick();
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk_reset_outputs("rst");

    // Reads only: addresses 0..9
    tick();
    clear_logs();
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rd_req = 1'b1; rd_addr = ADDR_W'(i);
      tick();
    end
    rd_req = 1'b0;
    repeat (4) tick();
    chk("rd_count", 32'(rlog_c.size()), 10);
    for (int i = 0; i < rlog_c.size() && i < 10; i++) begin
      chk("rd_latency", rlog_c[i] - c0, i + 2);
      chk("rd_data", rlog_d[i], i & 7);
    end
    chk("rd_no_writes", 32'(wlog_a.size()), 0);

    // FIFO fill while reads hold every slot
    clear_logs();
    rd_req = 1'b1; rd_addr = ADDR_W'(100);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(200 + k); wr_data = DATA_W'(k + 1);
      @(negedge CLOCK_50);
      acc = wr_ready;
      tick();
      if (acc) k++;
    end
    chk("fill_accepted", k, 4);
    @(negedge CLOCK_50);
    chk("fill_ready_low", 32'(wr_ready), 0);
    tick();
    rd_req = 1'b0;
    r = cyc;
    for (int c = 0; c < 8 && k < 5; c++) begin
      @(negedge CLOCK_50);
      acc = wr_ready;
      tick();
      if (acc) k++;
    end
    wr_valid = 1'b0;
    repeat (8) tick();
    chk("fill_5th_accepted", k, 5);
    chk("fill_wr_count", 32'(wlog_a.size()), 5);
    for (int i = 0; i < wlog_a.size() && i < 5; i++) begin
      chk("fill_wr_addr", wlog_a[i], 200 + i);
      chk("fill_wr_data", wlog_d[i], i + 1);
    end
    if (wlog_c.size() >= 4) begin
      chk("fill_first_wr_cyc", wlog_c[0], r + 1);
      for (int i = 1; i < 4; i++) chk("fill_consecutive", wlog_c[i] - wlog_c[0], i);
    end
    for (int i = 0; i < 5; i++) chk("fill_ram", ram_rd(200 + i), i + 1);

    // Alternating writes and reads
    clear_logs();
    for (int p = 0; p < 8; p++) begin
      rd_req = 1'b0;
      wr_valid = 1'b1; wr_addr = ADDR_W'(300 + p); wr_data = DATA_W'(p + 3);
      @(negedge CLOCK_50);
      chk("il_wr_ready", 32'(wr_ready), 1);
      tick();
      wr_valid = 1'b0;
      rd_req = 1'b1; rd_addr = ADDR_W'(10 + p);
      riss.push_back(cyc);
      tick();
    end
    rd_req = 1'b0;
    repeat (6) tick();
    chk("il_rd_count", 32'(rlog_c.size()), 8);
    for (int i = 0; i < rlog_c.size() && i < 8; i++) begin
      chk("il_rd_latency", rlog_c[i] - riss[i], 2);
      chk("il_rd_data", rlog_d[i], (10 + i) & 7);
    end
    chk("il_wr_count", 32'(wlog_a.size()), 8);
    for (int i = 0; i < wlog_a.size() && i < 8; i++) begin
      chk("il_wr_addr", wlog_a[i], 300 + i);
      chk("il_wr_data", wlog_d[i], (i + 3) & 7);
    end

    // Clear with two writes pending, plus an ignored second clear_start
    clear_logs();
    rd_req = 1'b1; rd_addr = ADDR_W'(50);
    wr_valid = 1'b1; wr_addr = ADDR_W'(400); wr_data = 3'd6;
    tick();
    wr_addr = ADDR_W'(401); wr_data = 3'd7;
    tick();
    wr_valid = 1'b0;
    clear_start = 1'b1; clear_color = 3'd5;
    tick();
    clear_start = 1'b0; clear_color = 3'd0; rd_req = 1'b0;
    repeat (8) tick();
    clear_start = 1'b1; clear_color = 3'd2;
    tick();
    clear_start = 1'b0;
    repeat (60) tick();
    chk("cp_wr_count", 32'(wlog_a.size()), 18);
    if (wlog_a.size() >= 2) begin
      chk("cp_pend0_addr", wlog_a[0], 400);
      chk("cp_pend0_data", wlog_d[0], 6);
      chk("cp_pend1_addr", wlog_a[1], 401);
      chk("cp_pend1_data", wlog_d[1], 7);
    end
    for (int i = 2; i < wlog_a.size() && i < 18; i++) begin
      chk("cp_sweep_addr", wlog_a[i], i - 2);
      chk("cp_sweep_data", wlog_d[i], 5);
    end
    chk("cp_done_count", done_cnt, 1);
    chk("cp_ready_in_busy", ready_in_busy, 0);
    chk("cp_done_busy_low", done_busy_bad, 0);

    // Clear timing with empty FIFO and no reads
    clear_logs();
    t = cyc;
    clear_start = 1'b1; clear_color = 3'd3;
    @(negedge CLOCK_50);
    chk("ct_busy_before", 32'(clear_busy), 0);
    tick();
    clear_start = 1'b0;
    repeat (30) tick();
    chk("ct_busy_rise", busy_first, t + 1);
    chk("ct_busy_len", busy_cnt, FB_DEPTH + 1);
    chk("ct_done_count", done_cnt, 1);
    chk("ct_done_cyc", done_cyc, busy_first + busy_cnt);
    chk("ct_done_busy_low", done_busy_bad, 0);
    chk("ct_wr_count", 32'(wlog_a.size()), FB_DEPTH);
    if (wlog_a.size() == FB_DEPTH) chk("ct_last_addr", wlog_a[FB_DEPTH - 1], FB_DEPTH - 1);

    // Reset in the middle of a sweep
    clear_logs();
    clear_start = 1'b1; clear_color = 3'd4;
    tick();
    clear_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge CLOCK_50);
      if (mem_we === 1'b1 && mem_addr == ADDR_W'(7)) found = 1'b1;
      else tick();
    end
    chk("rmc_reached_addr7", 32'(found), 1);
    tick();
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("rmc_wr_ready_in_reset", 32'(wr_ready), 0);
    tick();
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk_reset_outputs("rmc");
    wsz = wlog_a.size();
    repeat (25) tick();
    chk("rmc_no_more_writes", 32'(wlog_a.size()), 32'(wsz));
    chk("rmc_no_done", done_cnt, 0);
    chk("rmc_not_busy", 32'(clear_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Arbitrates the single-port on-chip framebuffer RAM of the Breakout design between three agents: the VGA scanout reader, the game renderer's pixel writer, and a built-in full-screen clear engine. Scanout reads have absolute priority and fixed latency so the VGA output never stalls. Renderer writes are buffered in a small FIFO and drained into idle slots. The block sits between the VGA timing/scanout logic and the framebuffer RAM, next to the game logic.

## Interface
- FB_DEPTH, 19200, number of framebuffer words (160x120 pixels)
- ADDR_W, 15, address width; must satisfy 2^ADDR_W >= FB_DEPTH
- DATA_W, 3, pixel width (RGB, 1 bit each)
- FIFO_DEPTH, 4, renderer write-buffer entries (power of two, >= 2)

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  scanout read request; may be asserted every cycle
- rd_addr  in  ADDR_W  scanout read address
- rd_valid  out  1  rd_data is valid this cycle
- rd_data  out  DATA_W  read pixel; equals mem_rdata
- wr_valid  in  1  renderer write offered
- wr_addr  in  ADDR_W  renderer write address
- wr_data  in  DATA_W  renderer pixel
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- clear_start  in  1  one-cycle pulse; request a full-screen clear
- clear_color  in  DATA_W  fill value; sampled with clear_start
- clear_busy  out  1  clear sequence in progress (DRAIN or CLEAR)
- clear_done  out  1  one-cycle pulse when the sweep finishes
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data; one-cycle read latency

## Operation
- States: IDLE, DRAIN, CLEAR.
- IDLE: renderer writes are pushed into the FIFO. wr_ready = !fifo_full && state==IDLE && !reset. There is no push when the FIFO is full, even if a pop occurs in the same cycle.
- A clear_start pulse in IDLE latches clear_color, sets clear_busy and enters DRAIN. A clear_start pulse in DRAIN or CLEAR is ignored.
- DRAIN: wr_ready=0. The FIFO keeps draining. When the FIFO is empty, the sweep counter is set to 0 and the state goes to CLEAR.
- CLEAR: wr_ready=0. The block writes the latched color to addresses 0..FB_DEPTH-1 in ascending order, using one idle slot per address. After the write to FB_DEPTH-1 is issued, it pulses clear_done, drops clear_busy and returns to IDLE.
- Slot priority each cycle:
  - rd_req first: issue a read.
  - Otherwise in IDLE/DRAIN, with the FIFO non-empty: pop the head and issue its write.
  - Otherwise in CLEAR: issue a sweep write and increment the counter.
  - Otherwise: no operation, mem_we=0.
- Writes reach the RAM in FIFO (acceptance) order. No coalescing, no address checking. Addresses >= FB_DEPTH are passed through unchanged.
- A read and a write to the same address in consecutive slots follow RAM semantics. The block does no forwarding.
- Reset mid-operation aborts everything: FIFO emptied, sweep abandoned, state IDLE, no clear_done pulse.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, clear_busy=0, clear_done=0. wr_ready is 0 while reset is high and 1 on the first cycle after reset is released.
- Read latency is fixed at 2 cycles:
  - rd_req sampled at cycle t;
  - mem_addr=rd_addr with mem_we=0 at t+1;
  - rd_valid=1 with rd_data=mem_rdata at t+2.
- Back-to-back reads give back-to-back rd_valid.
- Write path: a write accepted at cycle t is visible on the mem_* outputs no earlier than t+2 (t+1 push, t+2 registered issue), and later if reads occupy the slots.
- clear_busy rises the cycle after clear_start. clear_done is high for exactly one cycle, in the cycle when clear_busy falls.
- With no reads and an empty FIFO, a clear takes FB_DEPTH+1 cycles from clear_start to clear_done.

## Test plan
- Reads only: rd_req held for 10 cycles with rd_addr=0..9 (RAM model preloaded with addr&7) -> rd_valid high for cycles 2..11 with rd_data=0..7,0,1; mem_we stays 0.
- FIFO fill: rd_req held high, 5 writes offered -> wr_ready drops after 4 accepted. rd_req released -> 4 mem writes in order on consecutive cycles, the 5th accepted, and the RAM holds all 5 values.
- Interleave: writes and reads on alternating cycles -> read latency stays exactly 2 every time, and every write lands in order.
- Clear with FB_DEPTH=16 (override), clear_color=5, 2 writes pending -> the 2 pending writes land first, then addresses 0..15 are written with 5 and clear_done pulses once. A second clear_start during the sweep is ignored and wr_ready stays 0 throughout.
- Reset mid-clear at address 7 -> next cycle all outputs are at reset values, the FIFO is empty, no clear_done pulse, and wr_ready=1 after reset is released.
